// File: rtl/z_seq_ctrl_if.sv
// Handshake bundle between a sequence requester and the Z-register sequencer.
// master: requester/ALU side drives start, op and alu_done; slave: the sequencer drives the enables.
interface z_seq_ctrl_if;
  logic       start;
  logic [1:0] op;
  logic       alu_done;
  logic       alu_start;
  logic       ZInput;
  logic       ZLowOut;
  logic       ZHighOut;
  logic       LOin;
  logic       HIin;
  logic       RzIn;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, op, alu_done,
    input  alu_start, ZInput, ZLowOut, ZHighOut, LOin, HIin, RzIn, busy, done, err
  );

  modport slave (
    input  start, op, alu_done,
    output alu_start, ZInput, ZLowOut, ZHighOut, LOin, HIin, RzIn, busy, done, err
  );
endinterface

// File: rtl/z_seq_ctrl.sv
// Z-register sequencer: launch ALU, wait (with timeout), capture Z, move Z to Rz or LO/HI.
// Latency: done 5 cycles after start for op=00, 6 for MUL/DIV; start/op ignored while busy.
module z_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CW             = 7
) (
  input logic         clk,
  input logic         clr,
  z_seq_ctrl_if.slave zif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_XFER_LO, S_XFER_HI, S_DONE, S_ERR
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    op_q, op_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    case (state)
      S_IDLE: begin
        if (zif.start) begin
          if (zif.op == 2'b11) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_LAUNCH;
            op_nxt    = zif.op;
          end
        end
      end
      S_LAUNCH: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        // a result arriving on the last allowed cycle still counts as success
        if (zif.alu_done) begin
          state_nxt = S_CAPTURE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_CAPTURE: state_nxt = S_XFER_LO;
      S_XFER_LO: state_nxt = (op_q == 2'b00) ? S_DONE : S_XFER_HI;
      S_XFER_HI: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they track the state register exactly.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op_q          <= 2'b00;
      zif.alu_start <= 1'b0;
      zif.ZInput    <= 1'b0;
      zif.ZLowOut   <= 1'b0;
      zif.ZHighOut  <= 1'b0;
      zif.LOin      <= 1'b0;
      zif.HIin      <= 1'b0;
      zif.RzIn      <= 1'b0;
      zif.busy      <= 1'b0;
      zif.done      <= 1'b0;
      zif.err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      op_q          <= op_nxt;
      zif.alu_start <= (state_nxt == S_LAUNCH);
      zif.ZInput    <= (state_nxt == S_CAPTURE);
      zif.ZLowOut   <= (state_nxt == S_XFER_LO);
      zif.ZHighOut  <= (state_nxt == S_XFER_HI);
      zif.RzIn      <= (state_nxt == S_XFER_LO) && (op_nxt == 2'b00);
      zif.LOin      <= (state_nxt == S_XFER_LO) && (op_nxt != 2'b00);
      zif.HIin      <= (state_nxt == S_XFER_HI);
      zif.busy      <= (state_nxt != S_IDLE);
      zif.done      <= (state_nxt == S_DONE);
      zif.err       <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: doc/z_seq_ctrl.md
Z_SEQ_CTRL -- requirements
Module: z_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max cycles spent waiting for ALU completion (range 2..127).
REQ-002 Parameter CW, default 7, timeout counter width; SHALL satisfy 2^CW >= TIMEOUT_CYCLES.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to run one Z-register sequence; sampled only in IDLE.
REQ-006 op  input  2  00 = single-word result to Rz, 01 = MUL to LO/HI, 10 = DIV to LO/HI, 11 = reserved.
REQ-007 alu_done  input  1  multi-cycle ALU result valid on 64-bit Z data input; sampled only in WAIT.
REQ-008 alu_start  output  1  one-cycle launch pulse to ALU.
REQ-009 ZInput  output  1  Z register 64-bit capture enable.
REQ-010 ZLowOut  output  1  drive Z[31:0] onto bus.
REQ-011 ZHighOut  output  1  drive Z[63:32] onto bus.
REQ-012 LOin / HIin / RzIn  output  1 each  destination register write enables.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  one-cycle error pulse (reserved op or timeout).

Function
REQ-016 States: IDLE, LAUNCH, WAIT, CAPTURE, XFER_LO, XFER_HI, DONE, ERR; encoding is implementer's choice.
REQ-017 All outputs are Moore decodes of the current state; every output is 0 in IDLE.
REQ-018 IDLE: start=1 with op in {00,01,10} -> LAUNCH, op latched; start=1 with op=11 -> ERR; otherwise stay.
REQ-019 LAUNCH: alu_start=1; unconditional -> WAIT; timeout counter cleared to 0.
REQ-020 WAIT: alu_done=1 -> CAPTURE; else counter increments; alu_done=0 with counter == TIMEOUT_CYCLES-1 -> ERR.
REQ-021 alu_done and timeout limit in same cycle: alu_done wins (-> CAPTURE).
REQ-022 CAPTURE: ZInput=1 for exactly one cycle -> XFER_LO.
REQ-023 XFER_LO: ZLowOut=1; RzIn=1 if latched op=00, else LOin=1; -> DONE if op=00, else -> XFER_HI.
REQ-024 XFER_HI: ZHighOut=1, HIin=1 -> DONE.
REQ-025 DONE: done=1 -> IDLE; ERR: err=1 -> IDLE.
REQ-026 At most one of ZInput, ZLowOut, ZHighOut SHALL be high in any cycle; ZLowOut and ZHighOut never co-asserted.
REQ-027 start and op changes while busy=1 are ignored; latched op is held until IDLE.
REQ-028 alu_done in IDLE, LAUNCH or transfer states is ignored.
REQ-029 Latency (alu_done in first WAIT cycle): done high 5 cycles after start-sampling edge for op=00, 6 cycles for op=01/10.
REQ-030 start held high continuously SHALL start a new sequence on the cycle after DONE/ERR returns to IDLE (one IDLE cycle minimum between sequences).

Reset
REQ-031 clr=0 SHALL force IDLE immediately, independent of clk, and clear counter and latched op.
REQ-032 While clr=0 and in the first cycle after release, all outputs are 0.
REQ-033 Reset asserted mid-sequence (any state) aborts without done or err pulse; no further enables asserted.

Verification
REQ-034 op=00, start 1 cycle, alu_done high in first WAIT cycle -> alu_start@1, ZInput@3, ZLowOut+RzIn@4, done@5, LOin/HIin never high.
REQ-035 op=01, alu_done after 10 WAIT cycles -> ZInput, then ZLowOut+LOin, then ZHighOut+HIin, then done on consecutive cycles; busy high throughout.
REQ-036 op=10, alu_done never asserted, TIMEOUT_CYCLES=64 -> exactly 64 WAIT cycles, then err for 1 cycle, no ZInput, returns to IDLE.
REQ-037 op=11 with start -> err on next cycle, alu_start never asserted, busy high for 1 cycle only.
REQ-038 alu_done coincident with final timeout cycle -> CAPTURE taken, done pulses, err stays 0.
REQ-039 clr pulsed low during XFER_LO of an op=01 sequence -> all outputs 0 asynchronously, HIin and done never asserted; subsequent start runs a clean sequence.
